// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: frame states and
// oversampling constants.
package uart_rx_pkg;

    // Frame state machine states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_t;

    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned MID_SAMPLE  = 7;
    localparam int unsigned LAST_SAMPLE = 15;

endpackage

// File: rtl/baud_gen_rx_tick.sv
// Oversample tick generator for the UART receiver. Emits a one-clock tick
// every CLKS_PER_SAMPLE clocks; held cleared while disabled so the first
// tick phase is aligned to the moment it is enabled.
module baud_gen_rx_tick
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_SAMPLE = 27
) (
    input  logic clock,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == CW'(CLKS_PER_SAMPLE - 1));

    // Free-running divider, wraps at terminal count, cleared while disabled
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop synchroniser, 16x oversampling, frame FSM.
// Emits one byte per valid frame with a one-cycle rx_valid pulse; a low stop
// bit gives a frame_err pulse instead. Define UART_RX_PARITY_EN to add an
// even-parity bit (11-bit frame) and the parity_err output.
module uart_rx_core
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_SAMPLE = 27,
    parameter int unsigned DATA_BITS       = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,output logic                 parity_err
`endif
);

    localparam int unsigned SCW = $clog2(OVERSAMPLE);
    localparam int unsigned BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_t            state, state_next;
    logic                 rx_meta, rx_s;
    logic                 tick, tick_en;
    logic [SCW-1:0]       samp_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 samp_clr, take_bit, done_ok, done_err, par_bad;
`ifdef UART_RX_PARITY_EN
    logic                 par_take, par_bit;
`endif

    assign tick_en = (state != IDLE);
    assign busy    = (state != IDLE);

    baud_gen_rx_tick #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .clock (clock),
        .rst   (rst),
        .enable(tick_en),
        .tick  (tick)
    );

    // Two-flop synchroniser for the asynchronous line, idles high
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame state register
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        state_next = state;
        samp_clr   = 1'b0;
        take_bit   = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_take   = 1'b0;
`endif
        case (state)
            IDLE: begin
                samp_clr = 1'b1;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (tick && samp_cnt == SCW'(MID_SAMPLE)) begin
                    samp_clr   = 1'b1;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && samp_cnt == SCW'(LAST_SAMPLE)) begin
                    take_bit = 1'b1;
                    if (bit_cnt == BCW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick && samp_cnt == SCW'(LAST_SAMPLE)) begin
                    par_take   = 1'b1;
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && samp_cnt == SCW'(LAST_SAMPLE)) begin
                    if (rx_s) begin
                        done_ok    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        done_err   = 1'b1;
                        state_next = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    assign par_bad = (^shreg) ^ par_bit;
`else
    assign par_bad = 1'b0;
`endif

    // Sample/bit counters, shift register and output pulses
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (samp_clr) begin
                samp_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                if (tick)     samp_cnt <= samp_cnt + SCW'(1);
                if (take_bit) bit_cnt  <= bit_cnt + BCW'(1);
            end
            if (take_bit) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
            if (par_take) par_bit <= rx_s;
            parity_err <= (done_ok || done_err) && par_bad;
`endif
            rx_valid  <= done_ok && !par_bad;
            frame_err <= done_err;
            if (done_ok && !par_bad) rx_data <= shreg;
        end
    end

endmodule
